// File: rtl/msg_decrypt_engine_if.sv
// Single-port data-memory bus shared between the decrypt engine (master) and memory (slave).
// Read data is synchronous: valid the cycle after mem_addr is presented.
interface msg_decrypt_engine_if;
  logic [7:0] mem_addr;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/msg_decrypt_engine.sv
// LFSR-keystream message decryptor: recovers tap pattern and seed from the space preamble,
// strips leading spaces, writes plaintext back and pads the tail with spaces.
module msg_decrypt_engine #(
  parameter int unsigned CT_BASE = 64,
  parameter int unsigned PT_BASE = 0,
  parameter int unsigned MSG_LEN = 64,
  parameter int unsigned PRE_MIN = 10
) (
  input  logic                 clk,
  input  logic                 init_n,
  input  logic                 bgn,
  output logic                 ack,
  msg_decrypt_engine_if.master mem,
  output logic [3:0]           pt_no,
  output logic [6:0]           lfsr_init,
  output logic                 err
);

  localparam int unsigned NumPt = 9;
  localparam logic [6:0] TAPS [NumPt] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                          7'h69, 7'h5C, 7'h7E, 7'h7B};

  localparam logic [7:0] CtBaseB  = 8'(CT_BASE);
  localparam logic [7:0] PtBaseB  = 8'(PT_BASE);
  localparam logic [7:0] MsgLenB  = 8'(MSG_LEN);
  localparam logic [7:0] MsgLastB = 8'(MSG_LEN - 1);
  localparam logic [7:0] PreMinB  = 8'(PRE_MIN);
  localparam logic [7:0] PreLastB = 8'(PRE_MIN - 1);

  typedef enum logic [2:0] {StIdle, StRd, StEval, StFill, StDone} state_e;

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
    return {s[5:0], ^(s & tap)};
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       i_q, i_d;
  logic [7:0]       o_q, o_d;
  logic [NumPt-1:0] valid_q, valid_d;
  logic [6:0]       cand_q [NumPt];
  logic [6:0]       cand_d [NumPt];
  logic [6:0]       cand_step [NumPt];
  logic             strip_q, strip_d;
  logic [3:0]       pt_no_q, pt_no_d;
  logic [6:0]       lfsr_init_q, lfsr_init_d;
  logic             err_q, err_d;
  logic             ack_q, ack_d;

  logic [6:0] key;
  logic [6:0] ks;
  logic       parity_ok;
  logic [7:0] p;
  logic       keep;
  logic [3:0] pt_sel;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q     <= StIdle;
      i_q         <= '0;
      o_q         <= '0;
      valid_q     <= '0;
      strip_q     <= 1'b0;
      pt_no_q     <= '0;
      lfsr_init_q <= '0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      for (int j = 0; j < NumPt; j++) cand_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      o_q         <= o_d;
      valid_q     <= valid_d;
      strip_q     <= strip_d;
      pt_no_q     <= pt_no_d;
      lfsr_init_q <= lfsr_init_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      for (int j = 0; j < NumPt; j++) cand_q[j] <= cand_d[j];
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    o_d         = o_q;
    valid_d     = valid_q;
    strip_d     = strip_q;
    pt_no_d     = pt_no_q;
    lfsr_init_d = lfsr_init_q;
    err_d       = err_q;
    for (int j = 0; j < NumPt; j++) begin
      cand_d[j]    = cand_q[j];
      cand_step[j] = lfsr_step(cand_q[j], TAPS[j]);
    end
    mem.mem_addr  = '0;
    mem.mem_wr    = 1'b0;
    mem.mem_wdata = '0;

    // Preamble bytes are spaces, so ciphertext ^ 0x20 exposes the keystream directly.
    key       = mem.mem_rdata[6:0] ^ 7'h20;
    ks        = (i_q == 8'd0) ? key : cand_step[pt_no_q];
    parity_ok = ~^mem.mem_rdata;
    p         = parity_ok ? {1'b0, mem.mem_rdata[6:0] ^ ks} : 8'h80;
    keep      = (i_q >= PreMinB) && !(strip_q && (p == 8'h20));
    pt_sel    = pt_no_q;

    unique case (state_q)
      StIdle: begin
        if (!bgn) begin
          state_d = StRd;
          err_d   = 1'b0;
          valid_d = '0;
          i_d     = '0;
          o_d     = '0;
          strip_d = 1'b1;
        end
      end
      StRd: begin
        mem.mem_addr = CtBaseB + i_q;
        state_d      = StEval;
      end
      StEval: begin
        if (i_q == 8'd0) begin
          for (int j = 0; j < NumPt; j++) cand_d[j] = key;
          valid_d     = '1;
          lfsr_init_d = key;
        end else begin
          for (int j = 0; j < NumPt; j++) cand_d[j] = cand_step[j];
          if (i_q < PreMinB) begin
            for (int j = 0; j < NumPt; j++) begin
              valid_d[j] = valid_q[j] & (cand_step[j] == key);
            end
          end
        end

        if ((i_q >= PreMinB) && (p != 8'h20)) strip_d = 1'b0;
        if (keep) begin
          mem.mem_addr  = PtBaseB + o_q;
          mem.mem_wr    = 1'b1;
          mem.mem_wdata = p;
          o_d           = o_q + 8'd1;
        end
        i_d = i_q + 8'd1;

        // Downward scan so the lowest surviving index wins ties.
        for (int j = NumPt - 1; j >= 0; j--) begin
          if (valid_d[j]) pt_sel = 4'(j);
        end

        if ((i_q == PreLastB) && !(|valid_d)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          if (i_q == PreLastB) pt_no_d = pt_sel;
          if (i_q < MsgLastB)    state_d = StRd;
          else if (o_d < MsgLenB) state_d = StFill;
          else                    state_d = StDone;
        end
      end
      StFill: begin
        mem.mem_addr  = PtBaseB + o_q;
        mem.mem_wr    = 1'b1;
        mem.mem_wdata = 8'h20;
        o_d           = o_q + 8'd1;
        if (o_d == MsgLenB) state_d = StDone;
      end
      StDone: begin
        if (bgn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ack is asserted one edge after entering DONE and cleared on the edge that sees bgn high.
  assign ack_d     = (state_q == StDone) && !bgn;
  assign ack       = ack_q;
  assign pt_no     = pt_no_q;
  assign lfsr_init = lfsr_init_q;
  assign err       = err_q;

endmodule

// File: tb/tb_msg_decrypt_engine.sv
// Directed bench: encrypts a known message into a memory model, runs the engine, checks
// plaintext, detected pattern/seed, error flag and ack latency.
module tb_msg_decrypt_engine;

  logic       clk;
  logic       init_n;
  logic       bgn;
  logic       ack;
  logic [3:0] pt_no;
  logic [6:0] lfsr_init;
  logic       err;

  msg_decrypt_engine_if bus ();

  msg_decrypt_engine dut (
    .clk       (clk),
    .init_n    (init_n),
    .bgn       (bgn),
    .ack       (ack),
    .mem       (bus.master),
    .pt_no     (pt_no),
    .lfsr_init (lfsr_init),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  int         wr_cnt;
  int         addr_cnt;

  initial begin
    wr_cnt   = 0;
    addr_cnt = 0;
  end

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_wr === 1'b1) wr_cnt <= wr_cnt + 1;
    if (bus.mem_addr !== 8'h00) addr_cnt <= addr_cnt + 1;
  end

  int    total;
  int    bad;
  string msg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pt_byte(input int k);
    if (k < msg.len()) return msg[k];
    return 8'h20;
  endfunction

  task automatic mem_fill(input int base, input logic [7:0] d, input int n);
    @(negedge clk);
    for (int a = 0; a < n; a++) begin
      ld_en   = 1'b1;
      ld_addr = 8'(base + a);
      ld_data = d;
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  // Builds the 64-byte ciphertext: pre spaces, message, trailing spaces.
  task automatic load_ct(input int pre, input logic [6:0] tap, input logic [6:0] init,
                         input int flip, input bit bad_pre);
    logic [6:0] s;
    logic [7:0] p;
    logic [7:0] c;
    s = init;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      p       = (i < pre) ? 8'h20 : pt_byte(i - pre);
      c[6:0]  = p[6:0] ^ s;
      c[7]    = ^c[6:0];
      if (i == flip) c[7] = ~c[7];
      if (bad_pre && (i < 10)) c = ((i % 2) == 0) ? 8'h00 : 8'h7F;
      s       = {s[5:0], ^(s & tap)};
      ld_en   = 1'b1;
      ld_addr = 8'(64 + i);
      ld_data = c;
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  // Drops bgn, counts edges after the start edge until ack is seen (bounded).
  task automatic run(output int lat);
    @(negedge clk);
    bgn = 1'b0;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (ack === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_bgn();
    @(negedge clk);
    bgn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pt(input string tag, input int bad_idx);
    logic [7:0] e;
    for (int k = 0; k < 64; k++) begin
      e = (k == bad_idx) ? 8'h80 : pt_byte(k);
      chk($sformatf("%s_pt%0d", tag, k), 32'(mem[k]), 32'(e));
    end
  endtask

  int lat;
  int w0;
  int a0;

  initial begin
    total  = 0;
    bad    = 0;
    msg    = "Mr. Watson, come here. I want to see you.";
    ld_en  = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    bgn    = 1'b1;
    init_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_wr", 32'(bus.mem_wr), 32'h0);
    chk("rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_ptno", 32'(pt_no), 32'h0);
    chk("rst_init", 32'(lfsr_init), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    init_n = 1'b1;

    // bgn held high: engine stays idle.
    w0 = wr_cnt;
    a0 = addr_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_writes", 32'(wr_cnt - w0), 32'h0);
    chk("idle_addr", 32'(addr_cnt - a0), 32'h0);
    chk("idle_ack", 32'(ack), 32'h0);

    // Case 1: tap 0x60, seed 0x01, 10-space preamble.
    load_ct(10, 7'h60, 7'h01, -1, 1'b0);
    mem_fill(0, 8'hAA, 64);
    w0 = wr_cnt;
    run(lat);
    chk("c1_lat", 32'(lat), 32'd139);
    chk("c1_ptno", 32'(pt_no), 32'h0);
    chk("c1_init", 32'(lfsr_init), 32'h01);
    chk("c1_err", 32'(err), 32'h0);
    chk("c1_writes", 32'(wr_cnt - w0), 32'd64);
    release_bgn();
    chk("c1_ack_drop", 32'(ack), 32'h0);
    check_pt("c1", -1);

    // Case 2: tap 0x7B (index 8), seed 0x55, 15-space preamble; also ack hold behaviour.
    load_ct(15, 7'h7B, 7'h55, -1, 1'b0);
    mem_fill(0, 8'hAA, 64);
    run(lat);
    chk("c2_lat", 32'(lat), 32'd144);
    chk("c2_ptno", 32'(pt_no), 32'h8);
    chk("c2_init", 32'(lfsr_init), 32'h55);
    chk("c2_err", 32'(err), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    chk("c2_ack_hold", 32'(ack), 32'h1);
    @(negedge clk);
    bgn = 1'b1;
    #1;
    chk("c2_ack_prerise", 32'(ack), 32'h1);
    @(posedge clk);
    #1;
    chk("c2_ack_drop", 32'(ack), 32'h0);
    check_pt("c2", -1);

    // Case 3: parity error on ciphertext byte 30 maps to plaintext byte 20.
    load_ct(10, 7'h60, 7'h01, 30, 1'b0);
    mem_fill(0, 8'hAA, 64);
    run(lat);
    chk("c3_lat", 32'(lat), 32'd139);
    chk("c3_err", 32'(err), 32'h0);
    release_bgn();
    check_pt("c3", 20);

    // Case 4: preamble matches no pattern.
    load_ct(10, 7'h60, 7'h01, -1, 1'b1);
    mem_fill(0, 8'hAA, 64);
    w0 = wr_cnt;
    run(lat);
    chk("c4_lat", 32'(lat), 32'd21);
    chk("c4_err", 32'(err), 32'h1);
    chk("c4_init", 32'(lfsr_init), 32'h20);
    chk("c4_writes", 32'(wr_cnt - w0), 32'h0);
    release_bgn();
    chk("c4_pt0", 32'(mem[0]), 32'hAA);

    // Case 5: reset mid-run, then a clean rerun of case 1.
    load_ct(10, 7'h60, 7'h01, -1, 1'b0);
    mem_fill(0, 8'hAA, 64);
    @(negedge clk);
    bgn = 1'b0;
    @(posedge clk);
    repeat (50) @(posedge clk);
    #1;
    init_n = 1'b0;
    #1;
    chk("c5_ack", 32'(ack), 32'h0);
    chk("c5_wr", 32'(bus.mem_wr), 32'h0);
    chk("c5_addr", 32'(bus.mem_addr), 32'h0);
    @(negedge clk);
    bgn = 1'b1;
    @(negedge clk);
    init_n = 1'b1;
    mem_fill(0, 8'hAA, 64);
    run(lat);
    chk("c5_lat", 32'(lat), 32'd139);
    chk("c5_ptno", 32'(pt_no), 32'h0);
    chk("c5_init", 32'(lfsr_init), 32'h01);
    chk("c5_err", 32'(err), 32'h0);
    release_bgn();
    check_pt("c5", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
